// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// State encoding, RV32I funct3/opcode values and the latched request bundle.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension
// and the natural-alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        aligned
);

    logic        is_b;
    logic        is_h;
    logic [7:0]  lb;
    logic [15:0] lh;

    assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
    assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);
    assign lb   = rdata[{addr_lo, 3'b000} +: 8];
    assign lh   = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        wstrb   = 4'b1111;
        wdata   = store_data;
        aligned = (addr_lo == 2'b00);
        unique case (1'b1)
            is_b: begin
                wstrb   = 4'b0001 << addr_lo;
                wdata   = {4{store_data[7:0]}};
                aligned = 1'b1;
            end
            is_h: begin
                wstrb   = 4'b0011 << {addr_lo[1], 1'b0};
                wdata   = {2{store_data[15:0]}};
                aligned = ~addr_lo[0];
            end
            default: ;
        endcase
    end

    // Unknown funct3 values behave as a plain word access.
    always_comb begin
        load_data = rdata;
        unique case (funct3)
            F3_B:    load_data = {{24{lb[7]}}, lb};
            F3_BU:   load_data = {24'b0, lb};
            F3_H:    load_data = {{16{lh[15]}}, lh};
            F3_HU:   load_data = {16'b0, lh};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: one bus transaction per
// load/store, core held via stall until the access completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid
);

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    lsu_state_e  state;
    lsu_req_t    req_q;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        access;
    logic        idle;
    logic        expired;
    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_aligned;

    assign access  = mem_read | mem_write;
    assign idle    = (state == IDLE);
    assign expired = (cnt >= TMAX);

    // Live inputs are checked/steered in IDLE; latched ones afterwards.
    assign al_f3 = idle ? funct3 : req_q.f3;
    assign al_lo = idle ? address[1:0] : req_q.addr[1:0];

    lsu_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_lo),
        .store_data (store_data),
        .rdata      (bus_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .aligned    (al_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (access && al_aligned) begin
                        req_q.addr  <= address;
                        req_q.f3    <= funct3;
                        req_q.we    <= mem_write;
                        req_q.wstrb <= mem_write ? al_wstrb : 4'b0000;
                        req_q.wdata <= al_wdata;
                        cnt         <= '0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (bus_ready) begin
                        state <= RESP;
                    end else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end
                end
                RESP: begin
                    cnt <= cnt + 8'd1;
                    if (bus_rvalid) begin
                        rdata_q <= req_q.we ? 32'b0 : al_load;
                        state   <= DONE;
                    end else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so the core is released the instant reset asserts.
    assign stall      = rst_n & access & al_aligned & (state != DONE);
    assign misaligned = rst_n & idle & access & ~al_aligned;
    assign bus_error  = err_q;
    assign read_data  = (state == DONE) ? rdata_q : 32'b0;

    assign bus_valid = (state == REQ);
    assign bus_addr  = {req_q.addr[31:2], 2'b00};
    assign bus_we    = req_q.we;
    assign bus_wstrb = req_q.wstrb;
    assign bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized and directed
// accesses against a behavioural memory-access model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] address = '0;
    logic [31:0] store_data = '0;
    logic [31:0] read_data;
    logic        stall;
    logic        misaligned;
    logic        bus_error;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_rvalid = 1'b0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .address    (address),
        .store_data (store_data),
        .read_data  (read_data),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mis;
        bit          is_load;
        logic [31:0] rd;
        bit          err;
        int          stalls;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          mode;
        int          rdly;
        int          vdly;
        logic [31:0] rdata;
    } plan_t;

    resp_t resp_q[$];
    req_t  req_q[$];
    plan_t plan_q[$];

    int checks = 0;
    int fails  = 0;
    bit done   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == F3_B || f3 == F3_BU) return 1;
        if (f3 == F3_H || f3 == F3_HU) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] rdat);
        logic [31:0] v;
        int idx;
        idx = int'(a % 4);
        if (f3 == F3_B || f3 == F3_BU) begin
            v = (rdat >> (8 * idx)) % 256;
            if (f3 == F3_B && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (f3 == F3_H || f3 == F3_HU) begin
            v = (rdat >> (16 * (idx / 2))) % 65536;
            if (f3 == F3_H && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdat;
        end
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input int mode, input int rdly, input int vdly,
                         input logic [31:0] rdat);
        resp_t r;
        req_t  q;
        plan_t p;
        int n;
        int need;
        int k;
        n = acc_size(f3);
        r.mis = (a % n) != 0;
        r.is_load = !wr;
        need = rdly + vdly + 2;
        r.err = (mode == 1) || (need > TO);
        r.stalls = r.mis ? 0 : (r.err ? 1 + TO : 1 + need);
        r.rd = (r.mis || r.err || wr) ? 32'h0 : model_load(f3, a, rdat);
        resp_q.push_back(r);
        if (!r.mis) begin
            if (mode != 1) begin
                q.addr = a - (a % 4);
                q.we = wr;
                q.wstrb = 4'(((1 << n) - 1) << (a % 4));
                if (n == 1) q.wdata = (d % 256) * 32'h0101_0101;
                else if (n == 2) q.wdata = (d % 65536) * 32'h0001_0001;
                else q.wdata = d;
                req_q.push_back(q);
            end
            p.mode = mode; p.rdly = rdly; p.vdly = vdly; p.rdata = rdat;
            plan_q.push_back(p);
        end
        mem_read = rd; mem_write = wr; funct3 = f3;
        address = a; store_data = d;
        #1;
        k = 0;
        while (stall && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        if (stall) begin
            $display("FAIL stall_hang actual=%0d required=%0d", k, r.stalls);
            $fatal(1, "stall never released");
        end
        @(posedge clk); #1;
    endtask

    // Bus slave following the per-transaction plan.
    initial begin
        plan_t p;
        int k;
        forever begin
            @(posedge clk); #1;
            if (bus_valid && rst_n && plan_q.size() > 0) begin
                p = plan_q.pop_front();
                if (p.mode == 1) begin
                    k = 0;
                    while (bus_valid && k < 60) begin
                        @(posedge clk); #1;
                        k++;
                    end
                end else begin
                    repeat (p.rdly) begin @(posedge clk); #1; end
                    bus_ready = 1'b1;
                    @(posedge clk); #1;
                    bus_ready = 1'b0;
                    repeat (p.vdly) begin @(posedge clk); #1; end
                    bus_rdata = p.rdata;
                    bus_rvalid = 1'b1;
                    @(posedge clk); #1;
                    bus_rvalid = 1'b0;
                    bus_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        resp_t r;
        req_t  q;
        int scnt;
        scnt = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (done) begin
                chk("queues_drained", resp_q.size() + req_q.size(), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
                $finish;
            end
            if (!rst_n) begin
                chk("rst_bus_valid", {31'b0, bus_valid}, 0);
                chk("rst_stall", {31'b0, stall}, 0);
                chk("rst_read_data", read_data, 0);
                chk("rst_flags", {25'b0, misaligned, bus_error, bus_we, bus_wstrb}, 0);
                resp_q.delete();
                req_q.delete();
                scnt = 0;
            end else begin
                if (stall) scnt++;
                if (bus_valid && bus_ready) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 1, 0);
                    end else begin
                        q = req_q.pop_front();
                        chk("bus_addr", bus_addr, q.addr);
                        chk("bus_we", {31'b0, bus_we}, {31'b0, q.we});
                        if (q.we) begin
                            chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, q.wstrb});
                            chk("bus_wdata", bus_wdata, q.wdata);
                        end
                    end
                end
                if (misaligned || ((mem_read || mem_write) && !stall)) begin
                    if (resp_q.size() == 0) begin
                        chk("unexpected_resp", 1, 0);
                    end else begin
                        r = resp_q.pop_front();
                        chk("misaligned", {31'b0, misaligned}, {31'b0, r.mis});
                        chk("stall_cycles", scnt, r.stalls);
                        if (r.mis) begin
                            chk("mis_bus_valid", {31'b0, bus_valid}, 0);
                            chk("mis_read_data", read_data, 0);
                        end else begin
                            chk("bus_error", {31'b0, bus_error}, {31'b0, r.err});
                            if (r.is_load) chk("read_data", read_data, r.rd);
                        end
                    end
                    scnt = 0;
                end
            end
        end
    end

    initial begin
        logic [2:0]  ld_f3 [6];
        logic [2:0]  st_f3 [3];
        logic [2:0]  f3;
        logic [31:0] a;
        bit          wr;
        ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU, 3'b011};
        st_f3 = '{F3_B, F3_H, F3_W};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(1, 0, F3_W,  32'h100, 0, 0, 0, 0, 32'hDEAD_BEEF);
        issue(1, 0, F3_B,  32'h103, 0, 0, 0, 0, 32'h80AA_BBCC);
        issue(1, 0, F3_BU, 32'h103, 0, 0, 0, 0, 32'h80AA_BBCC);
        issue(1, 0, F3_HU, 32'h102, 0, 0, 0, 0, 32'h80AA_BBCC);
        issue(0, 1, F3_B,  32'h201, 32'h0000_00A5, 0, 0, 0, 32'h0);
        issue(0, 1, F3_H,  32'h202, 32'h0000_1234, 0, 0, 0, 32'h0);
        issue(1, 0, F3_H,  32'h101, 0, 0, 0, 0, 32'h0);
        issue(0, 1, F3_W,  32'h102, 32'h5555_AAAA, 0, 0, 0, 32'h0);
        issue(1, 0, F3_W,  32'h300, 0, 1, 0, 0, 32'h0);
        issue(1, 0, F3_W,  32'h304, 0, 0, 0, 6, 32'h1111_2222);
        issue(1, 0, F3_W,  32'h308, 0, 0, 0, 7, 32'h3333_4444);

        // Reset while the access sits in RESP.
        begin
            req_t  q;
            plan_t p;
            q.addr = 32'h400; q.we = 1'b0; q.wstrb = '0; q.wdata = '0;
            req_q.push_back(q);
            p.mode = 0; p.rdly = 0; p.vdly = 5; p.rdata = 32'h0BAD_0BAD;
            plan_q.push_back(p);
            mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; address = 32'h400;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            #2 rst_n = 1'b0;
            @(posedge clk); #1;
            mem_read = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;
        end
        issue(1, 0, F3_W, 32'h500, 0, 0, 1, 1, 32'hCAFE_F00D);

        for (int i = 0; i < 300; i++) begin
            wr = $urandom_range(0, 1) == 1;
            f3 = wr ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 5)];
            a = $urandom;
            issue(wr ? ($urandom_range(0, 3) == 0) : 1'b1, wr, f3, a, $urandom,
                  0, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                mem_read = 1'b0;
                mem_write = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        repeat (4) @(posedge clk);
        done = 1'b1;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage between the ALU and the data bus of the single-cycle RISC-V core. It takes the ALU's effective address, store data and `funct3`, issues one bus transaction with a valid/ready request and an rvalid response, and holds the core via `stall` until the access finishes. It returns fully aligned and extended load data on `read_data`, so the register-file write path uses it as-is. It also flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT`, default 64: cycles allowed from entering REQ until a response arrives; must be 2–255.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `mem_read` in 1: load instruction present (opcode 0000011).
- `mem_write` in 1: store instruction present (opcode 0100011).
- `funct3` in 3: access size and sign, per RV32I encoding.
- `address` in 32: effective address, from the ALU output.
- `store_data` in 32: rs2 data.
- `read_data` out 32: aligned, extended load result.
- `stall` out 1: freeze PC and register write while high.
- `misaligned` out 1: one-cycle pulse; access rejected.
- `bus_error` out 1: one-cycle pulse; timeout.
- `bus_valid` out 1: request valid.
- `bus_ready` in 1: request accepted.
- `bus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_we` out 1: write request.
- `bus_wstrb` out 4: byte-lane enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rdata` in 32: response data.
- `bus_rvalid` in 1: response valid.

## Operation
- Access = `mem_read | mem_write`. If both are high, the access is a write.
- Alignment:
  - Byte (`funct3` 000/100): always aligned.
  - Half (001/101): requires `addr[0]==0`.
  - Word (010): requires `addr[1:0]==0`.
  - Any other `funct3` is treated as word.
- Misaligned access in IDLE: no bus transaction; `misaligned` pulses; `stall` stays 0; `read_data`=0.
- FSM states:
  - IDLE: on an aligned access, latch address, `funct3`, we and wdata/wstrb, then go to REQ.
  - REQ: `bus_valid`=1. On `bus_ready`, go to RESP.
  - RESP: on `bus_rvalid`, register the steered read data, then go to DONE.
  - DONE: `stall`=0; `read_data` is held. Go to IDLE next cycle.
  - Timeout from REQ or RESP: go to DONE with `bus_error` pulse and `read_data`=0.
- `stall` = access & aligned & (state != DONE). It is combinational, so it rises in the same cycle the access appears.
- Store lanes:
  - SB: `wstrb` = 0001<<a[1:0]; `wdata` = byte replicated 4x.
  - SH: `wstrb` = 0011<<{a[1],0}; `wdata` = half replicated 2x.
  - SW: `wstrb` = 1111.
- Load lanes:
  - Byte: `rdata>>(8*a[1:0])`, then sign-extend (000) or zero-extend (100) from bit 7.
  - Half: `>>(16*a[1])`, then sign-extend (001) or zero-extend (101) from bit 15.
  - Word: passed through.
- Stores also wait for `bus_rvalid`, which acts as a write acknowledgement. `bus_rdata` is ignored for stores.
- Inputs are latched on leaving IDLE; input changes while stalled are ignored.

## Timing
- Reset: state IDLE. All outputs are 0, including `stall`, `bus_valid`, `read_data`, `misaligned` and `bus_error`. The FSM leaves reset and resets the timeout counter.
- Minimum latency with zero-wait bus: cycle 0 IDLE (stall=1), cycle 1 REQ (`bus_valid`=1, ready=1), cycle 2 RESP (rvalid=1), cycle 3 DONE (stall=0). That is 3 stall cycles.
- Bus protocol:
  - `bus_valid` and all request fields are registered and stable until `bus_ready`.
  - `bus_valid` deasserts the cycle after the handshake.
  - `bus_rvalid` is ignored outside RESP.
- Timeout counter: cleared on entering REQ and counts every cycle in REQ or RESP. When count == `TIMEOUT-1` with no completing event, go to DONE with error. If `bus_rvalid` arrives in that same cycle, the response wins and there is no error.
- Reset mid-transaction: `bus_valid` drops asynchronously; nothing is replayed.
- Back-to-back accesses: after DONE → IDLE, the next access starts in the IDLE cycle. One idle-visible cycle is inherent.

## Structure
- Shared package `lsu_pkg`:
  - State enum (IDLE, REQ, RESP, DONE).
  - `funct3` constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Opcode constants `OP_LOAD`, `OP_STORE`.
- Sub-module `lsu_align`: combinational lane steering (`wstrb`/`wdata`), load extraction/extension and the misalignment check. It is instantiated once. The FSM, timeout counter and registers live in the top module.

## Test plan
- LW addr 0x100, zero-wait bus, rdata 0xDEADBEEF → `bus_addr` 0x100, we=0; `read_data` 0xDEADBEEF in DONE; `stall` high exactly 3 cycles.
- LB addr 0x103, rdata 0x80AABBCC → `read_data` 0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr 0x102 → 0x000080AA.
- SB addr 0x201, data 0x000000A5 → `wstrb` 0010, `wdata` 0xA5A5A5A5, `bus_addr` 0x200. SH addr 0x202, data 0x1234 → `wstrb` 1100, `wdata` 0x12341234.
- LH addr 0x101 and SW addr 0x102 → `misaligned` pulse, `bus_valid` never rises, `stall`=0.
- `bus_ready` held 0 with `TIMEOUT`=8 → `bus_error` pulse after 8 cycles in REQ, `read_data`=0, `stall` drops in DONE. `bus_rvalid` on the final count cycle → no error.
- `rst_n` low during RESP → `bus_valid`/`stall`=0 immediately. After release, a new LW completes normally.
